// File: rtl/ddr_crc_pkg.sv
// Shared CRC-5 constants, FSM state type and the one-bit update used by the
// serial and parallel CRC paths.
package ddr_crc_pkg;
  localparam int CRC_WIDTH = 5;
  localparam logic [CRC_WIDTH-1:0] CRC_POLY = 5'b00101;
  localparam logic [CRC_WIDTH-1:0] CRC_SEED = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

  // x^5 + x^2 + 1, MSB-first
  function automatic logic [CRC_WIDTH-1:0] crc5_step(input logic [CRC_WIDTH-1:0] crc,
                                                     input logic bit_in);
    logic fb;
    fb = crc[CRC_WIDTH-1] ^ bit_in;
    return {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction
endpackage

// File: rtl/ddr_crc5_lfsr.sv
// CRC-5 register with a single-bit step and an unrolled whole-byte step.
// Preset has priority so a byte accepted together with init starts from the seed.
module ddr_crc5_lfsr
  import ddr_crc_pkg::*;
#(
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  preset,
  input  logic                  step,
  input  logic                  bit_in,
  input  logic                  byte_step,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic [CRC_WIDTH-1:0]  crc
);

  function automatic logic [CRC_WIDTH-1:0] crc5_byte(input logic [CRC_WIDTH-1:0] crc_in,
                                                     input logic [BYTE_WIDTH-1:0] b);
    logic [CRC_WIDTH-1:0] c;
    c = crc_in;
    for (int i = BYTE_WIDTH - 1; i >= 0; i--) c = crc5_step(c, b[i]);
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            crc <= CRC_SEED;
    else if (preset)    crc <= CRC_SEED;
    else if (step)      crc <= crc5_step(crc, bit_in);
    else if (byte_step) crc <= crc5_byte(crc, byte_in);
  end

endmodule

// File: rtl/ddr_crc5_engine.sv
// HDR-DDR CRC-5 engine: accumulates RX bytes and compares against the received CRC.
// Define DDR_CRC5_PARALLEL_EN for the one-shot byte update (2-cycle latency, never busy).
module ddr_crc5_engine
  import ddr_crc_pkg::*;
#(
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_rx_crc_en,
  input  logic                  i_rx_crc_init,
  input  logic [BYTE_WIDTH-1:0] i_rx_byte,
  input  logic                  i_rx_byte_valid,
  input  logic [CRC_WIDTH-1:0]  i_rx_crc_rcvd,
  input  logic                  i_rx_crc_check,
  output logic                  o_crc_busy,
  output logic [CRC_WIDTH-1:0]  o_crc_value,
  output logic                  o_crc_valid,
  output logic                  o_crc_match,
  output logic                  o_crc_error,
  output logic                  o_crc_overrun
);

  crc_state_e            state;
  logic [BYTE_WIDTH-1:0] sreg;
  logic [CRC_WIDTH-1:0]  crc, rcvd_q;
  logic accept, in_flight, cplt, step, byte_step, ovr_set;
  logic valid_q, match_q, error_q, ovr_q, pend;

  assign accept = i_rx_byte_valid & i_rx_crc_en & (state != SHIFT);

`ifdef DDR_CRC5_PARALLEL_EN
  // DONE is the cycle the latched byte is folded in; init there discards it
  assign in_flight = (state == DONE);
  assign cplt      = in_flight & ~i_rx_crc_init;
  assign step      = 1'b0;
  assign byte_step = cplt;
  assign ovr_set   = 1'b0;
  assign o_crc_busy = 1'b0;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state <= IDLE;
      sreg  <= '0;
    end else begin
      state <= accept ? DONE : IDLE;
      if (accept) sreg <= i_rx_byte;
    end
  end
`else
  localparam int CW = $clog2(BYTE_WIDTH);
  logic [CW-1:0] cnt;

  assign in_flight = (state == SHIFT);
  assign step      = in_flight & ~i_rx_crc_init;
  assign cplt      = step & (cnt == '0);
  assign byte_step = 1'b0;
  assign ovr_set   = i_rx_byte_valid & in_flight & ~i_rx_crc_init;
  assign o_crc_busy = in_flight;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (in_flight) begin
      if (i_rx_crc_init) begin
        state <= IDLE;
      end else begin
        sreg <= sreg << 1;
        cnt  <= cnt - 1'b1;
        if (cnt == '0) state <= DONE;
      end
    end else if (accept) begin
      sreg  <= i_rx_byte;
      cnt   <= CW'(BYTE_WIDTH - 1);
      state <= SHIFT;
    end else begin
      state <= IDLE;
    end
  end
`endif

  ddr_crc5_lfsr #(.BYTE_WIDTH(BYTE_WIDTH)) u_lfsr (
    .clk       (i_sys_clk),
    .rst       (i_sys_rst),
    .preset    (i_rx_crc_init),
    .step      (step),
    .bit_in    (sreg[BYTE_WIDTH-1]),
    .byte_step (byte_step),
    .byte_in   (sreg),
    .crc       (crc)
  );

  // A check that lands while a byte is in flight waits for the final CRC.
  // Check together with init compares the pre-init value.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      valid_q <= 1'b0;
      match_q <= 1'b0;
      error_q <= 1'b0;
      ovr_q   <= 1'b0;
      pend    <= 1'b0;
      rcvd_q  <= '0;
    end else begin
      valid_q <= cplt;
      match_q <= 1'b0;
      error_q <= 1'b0;
      if (i_rx_crc_init) ovr_q <= 1'b0;
      else if (ovr_set)  ovr_q <= 1'b1;
      if (pend & valid_q) begin
        match_q <= (crc == rcvd_q);
        error_q <= (crc != rcvd_q);
        pend    <= 1'b0;
      end
      if (i_rx_crc_init & in_flight) pend <= 1'b0;
      if (i_rx_crc_check) begin
        if (in_flight & ~i_rx_crc_init) begin
          pend   <= 1'b1;
          rcvd_q <= i_rx_crc_rcvd;
        end else begin
          match_q <= (crc == i_rx_crc_rcvd);
          error_q <= (crc != i_rx_crc_rcvd);
        end
      end
    end
  end

  assign o_crc_value   = crc;
  assign o_crc_valid   = valid_q;
  assign o_crc_match   = match_q;
  assign o_crc_error   = error_q;
  assign o_crc_overrun = ovr_q;

endmodule

// File: doc/ddr_crc5_engine.md
Name: ddr_crc5_engine

Overview:
- HDR-DDR CRC-5 engine sitting directly downstream of the RX deserializer.
- Consumes each deserialized data byte while RX asserts its CRC enable, and accumulates the running CRC-5 (x^5+x^2+1, MSB-first, seed 5'b11111).
- Compares the running CRC against the CRC word RX captures in the CRC state, and returns value/valid/match status to RX and the DDR CCC controller.

Parameters:
- CRC_WIDTH, 5, CRC register width.
- CRC_POLY, 5'b00101, feedback taps (x^5 implicit).
- CRC_SEED, 5'b11111, preset value.
- BYTE_WIDTH, 8, data byte width from RX.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  asynchronous, active-high reset.
- i_rx_crc_en  in  1  accumulate enable from RX; bytes are accepted only while high.
- i_rx_crc_init  in  1  one-cycle pulse; presets CRC to CRC_SEED.
- i_rx_byte  in  BYTE_WIDTH  deserialized data byte.
- i_rx_byte_valid  in  1  one-cycle strobe qualifying i_rx_byte.
- i_rx_crc_rcvd  in  CRC_WIDTH  CRC word received on the bus.
- i_rx_crc_check  in  1  one-cycle pulse requesting a compare.
- o_crc_busy  out  1  byte shifting in progress.
- o_crc_value  out  CRC_WIDTH  running CRC.
- o_crc_valid  out  1  one-cycle pulse when a byte finishes.
- o_crc_match  out  1  one-cycle pulse: compare passed.
- o_crc_error  out  1  one-cycle pulse: compare failed.
- o_crc_overrun  out  1  sticky flag: byte arrived while busy.

Behaviour:
- Reset (async, i_sys_rst=1):
  - o_crc_value=CRC_SEED.
  - o_crc_busy, o_crc_valid, o_crc_match, o_crc_error and o_crc_overrun are 0.
  - FSM=IDLE, bit counter=0, check-pending=0.
  - Reset mid-shift aborts the byte with no valid pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - When i_rx_byte_valid & i_rx_crc_en: latch byte into shift register, counter=7, go to SHIFT, o_crc_busy=1 from the next cycle.
  - When i_rx_byte_valid & !i_rx_crc_en: ignore the byte.
- SHIFT, one bit per clock, MSB first:
  - fb = crc[4] ^ bit.
  - crc <= {crc[3:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - After the 8th bit go to DONE.
- DONE (1 cycle): o_crc_valid=1, o_crc_busy=0, return to IDLE. Byte latency is valid strobe to o_crc_valid = 9 cycles.
- Back-to-back bytes: a valid in the DONE cycle is accepted (DONE->SHIFT directly, no bubble).
- i_rx_byte_valid in SHIFT: byte dropped and o_crc_overrun set; it clears only on i_rx_crc_init or reset.
- i_rx_crc_init:
  - In IDLE/DONE: CRC=CRC_SEED next cycle.
  - Same cycle as an accepted byte: preset applies first, so the byte is computed from the seed.
  - During SHIFT: aborts the byte, CRC=seed, FSM=IDLE, no o_crc_valid.
- i_rx_crc_check:
  - In IDLE: compare o_crc_value with i_rx_crc_rcvd. Next cycle, exactly one of o_crc_match/o_crc_error pulses.
  - In SHIFT/DONE: set check-pending and capture i_rx_crc_rcvd. The compare fires in the cycle after the byte completes, using the final CRC.
  - Check and init in the same cycle: compare uses the pre-init value.
- o_crc_value is always the registered CRC; it holds while i_rx_crc_en=0.

Optional Feature:
- Macro: DDR_CRC5_PARALLEL_EN.
- Defined: an unrolled combinational 8-step update. SHIFT is bypassed (IDLE->DONE), byte latency is 2 cycles, o_crc_busy is never asserted, and o_crc_overrun is never set.
- Undefined: the serial 8-cycle SHIFT behaviour above.
- Final CRC values are identical in both builds.

Decomposition:
- Package ddr_crc_pkg holds:
  - CRC_WIDTH, CRC_POLY, CRC_SEED.
  - FSM state enum (IDLE/SHIFT/DONE).
  - A crc5_step function (one bit) shared by the serial and parallel paths.
- One natural sub-module: ddr_crc5_lfsr (5-bit register + single-step/8-step update). The FSM, compare and flags stay in the top.

Test Plan:
- Reset, init, byte 0x00 -> o_crc_valid 9 cycles after the strobe, o_crc_value=5'b01111.
- Init, byte 0xFF -> o_crc_value=5'b11011. Then check with rcvd=5'b11011 -> o_crc_match pulse only; repeat with rcvd=5'b11010 -> o_crc_error pulse only.
- Init, bytes 0x00 then 0x00 back-to-back (second strobe in the DONE cycle) -> two valid pulses, final CRC=5'b00001, o_crc_overrun=0.
- Second byte strobed 3 cycles into SHIFT -> byte dropped, o_crc_overrun=1, CRC=5'b01111 (first byte only). Then init -> o_crc_overrun=0, CRC=5'b11111.
- Check pulse during SHIFT of 0xFF with rcvd=5'b11011 -> match pulses the cycle after o_crc_valid. Also assert i_sys_rst mid-SHIFT -> outputs return to reset values immediately, no valid pulse.
- Build with DDR_CRC5_PARALLEL_EN and rerun vectors 1-3 -> same CRCs, o_crc_valid 2 cycles after the strobe.
